// File: rtl/slink_phys_rx_oversample_if.sv
// Word handshake between the oversampling RX PHY and its consumer.
// The master (PHY) drives data/valid; the slave (consumer) drives ready.
interface slink_phys_rx_oversample_if #(
    parameter int DataWidth = 16
) ();
    logic [DataWidth-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/slink_phys_rx_oversample.sv
// Serial-link RX PHY that oversamples the forwarded clock and lanes with clk_i,
// schedules a delayed capture after each detected edge and queues words in a FIFO.
module slink_phys_rx_oversample #(
    parameter int NumLanes     = 8,
    parameter int EnDdr        = 1,
    parameter int SyncStages   = 2,
    parameter int FifoDepth    = 4,
    parameter int MaxSampleDly = 15,
    parameter int IdleCntWidth = 8,
    localparam int DataW       = NumLanes * ((EnDdr != 0) ? 2 : 1),
    localparam int DlyW        = $clog2(MaxSampleDly + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ddr_rcv_clk_i,
    input  logic [NumLanes-1:0]     ddr_i,
    input  logic [DlyW-1:0]         sample_dly_i,
    input  logic [IdleCntWidth-1:0] idle_cycles_i,
    input  logic                    clear_i,
    slink_phys_rx_oversample_if.master rx_o,
    output logic                    idle_o,
    output logic                    edge_err_o,
    output logic                    overflow_o
);
    typedef logic [DataW-1:0] phy_data_t;
    localparam int PtrW = $clog2(FifoDepth);

    logic [SyncStages-1:0]   sclk_q;
    logic [NumLanes-1:0]     lane_q [SyncStages];
    logic                    prev_q;
    logic                    sclk, rise, fall, any_edge, sched, idle_hit, idle_clr;
    logic [NumLanes-1:0]     slanes;

    logic                    pending_q, pending_d, type_q, type_d;
    logic [DlyW-1:0]         dly_q, dly_d, cnt;
    logic                    cap, cap_rise, err_evt;
    logic [IdleCntWidth-1:0] idle_cnt_q, idle_cnt_d;
    logic                    idle_q, idle_d;
    logic                    edge_err_q, overflow_q;

    logic                    push, pop, full, empty, do_push, ovf_evt;
    phy_data_t               push_data;
    phy_data_t               mem_q [FifoDepth];
    logic [PtrW:0]           wr_q, rd_q;

    // The TX parks its clock high, so the clock chain resets to 1 to avoid a fake fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q <= '1;
            prev_q <= 1'b1;
            for (int i = 0; i < SyncStages; i++) lane_q[i] <= '0;
        end else begin
            sclk_q    <= {sclk_q[SyncStages-2:0], ddr_rcv_clk_i};
            prev_q    <= sclk;
            lane_q[0] <= ddr_i;
            for (int i = 1; i < SyncStages; i++) lane_q[i] <= lane_q[i-1];
        end
    end

    assign sclk     = sclk_q[SyncStages-1];
    assign slanes   = lane_q[SyncStages-1];
    assign rise     = sclk & ~prev_q;
    assign fall     = ~sclk & prev_q;
    assign any_edge = rise | fall;
    assign sched    = (EnDdr != 0) ? any_edge : rise;
    assign idle_hit = (idle_cycles_i != '0) && (idle_cnt_q >= idle_cycles_i);
    assign idle_clr = idle_hit & ~any_edge;

    // The delay is applied from the edge-detect cycle, so a delay of 0 captures immediately.
    always_comb begin
        pending_d = pending_q;
        dly_d     = dly_q;
        type_d    = type_q;
        cap       = 1'b0;
        err_evt   = sched & pending_q;
        cnt       = sched ? sample_dly_i : dly_q;
        cap_rise  = sched ? rise : type_q;
        if (sched) type_d = rise;
        if (idle_clr) begin
            pending_d = 1'b0;
        end else if (sched || pending_q) begin
            if (cnt == '0) begin
                cap       = 1'b1;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
                dly_d     = cnt - 1'b1;
            end
        end
    end

    always_comb begin
        idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
        idle_d     = idle_q;
        if (any_edge) begin
            idle_cnt_d = '0;
            idle_d     = 1'b0;
        end else if (idle_hit) begin
            idle_d = 1'b1;
        end
    end

    if (EnDdr != 0) begin : g_ddr
        logic [NumLanes-1:0] low_q, low_d;
        logic                half_q, half_d;

        always_comb begin
            low_d  = low_q;
            half_d = half_q;
            if (idle_clr) begin
                half_d = 1'b0;
            end else if (cap && !cap_rise) begin
                low_d  = slanes;
                half_d = 1'b1;
            end else if (cap && cap_rise) begin
                half_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                low_q  <= '0;
                half_q <= 1'b0;
            end else begin
                low_q  <= low_d;
                half_q <= half_d;
            end
        end

        assign push      = cap & cap_rise & half_q;
        assign push_data = {slanes, low_q};
    end else begin : g_sdr
        assign push      = cap & cap_rise;
        assign push_data = slanes;
    end

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
    assign pop     = ~empty & rx_o.ready;
    assign do_push = push & (~full | pop);
    assign ovf_evt = push & full & ~pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q  <= 1'b0;
            type_q     <= 1'b0;
            dly_q      <= '0;
            idle_cnt_q <= '0;
            idle_q     <= 1'b1;
            edge_err_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
        end else begin
            pending_q  <= pending_d;
            type_q     <= type_d;
            dly_q      <= dly_d;
            idle_cnt_q <= idle_cnt_d;
            idle_q     <= idle_d;
            edge_err_q <= err_evt | (edge_err_q & ~clear_i);
            overflow_q <= ovf_evt | (overflow_q & ~clear_i);
            if (do_push) begin
                mem_q[wr_q[PtrW-1:0]] <= push_data;
                wr_q                  <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    assign rx_o.data  = mem_q[rd_q[PtrW-1:0]];
    assign rx_o.valid = ~empty;
    assign idle_o     = idle_q;
    assign edge_err_o = edge_err_q;
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_slink_phys_rx_oversample.sv
// Directed bench for the oversampling RX PHY: a DDR instance and an SDR instance,
// with a scoreboard of expected words checked on every handshake.
module tb_slink_phys_rx_oversample;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       fclk, fclk2;
    logic [7:0] lanes, lanes2;
    logic [3:0] sdly;
    logic [7:0] idle_cyc;
    logic       clr, rdy;
    logic       idle_d1, err_d1, ovf_d1;
    logic       idle_s, err_s, ovf_s;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  exp2_q[$];
    logic [15:0] rx_log[$];
    logic [7:0]  rx2_log[$];

    slink_phys_rx_oversample_if #(.DataWidth(16)) ifc_ddr ();
    slink_phys_rx_oversample_if #(.DataWidth(8))  ifc_sdr ();
    assign ifc_ddr.ready = rdy;
    assign ifc_sdr.ready = 1'b1;

    slink_phys_rx_oversample #(.EnDdr(1)) dut_ddr (
        .clk_i(clk), .rst_ni(rst_n), .ddr_rcv_clk_i(fclk), .ddr_i(lanes),
        .sample_dly_i(sdly), .idle_cycles_i(idle_cyc), .clear_i(clr),
        .rx_o(ifc_ddr), .idle_o(idle_d1), .edge_err_o(err_d1), .overflow_o(ovf_d1));

    slink_phys_rx_oversample #(.EnDdr(0)) dut_sdr (
        .clk_i(clk), .rst_ni(rst_n), .ddr_rcv_clk_i(fclk2), .ddr_i(lanes2),
        .sample_dly_i(sdly), .idle_cycles_i(8'd0), .clear_i(clr),
        .rx_o(ifc_sdr), .idle_o(idle_s), .edge_err_o(err_s), .overflow_o(ovf_s));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every accepted word must be the next expected one.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (ifc_ddr.valid && ifc_ddr.ready) begin
                rx_log.push_back(ifc_ddr.data);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ddr_unexpected_word actual=%0h required=none", ifc_ddr.data);
                end else chk("ddr_word", ifc_ddr.data, exp_q.pop_front());
            end
            if (ifc_sdr.valid) begin
                rx2_log.push_back(ifc_sdr.data);
                if (exp2_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sdr_unexpected_word actual=%0h required=none", ifc_sdr.data);
                end else chk("sdr_word", ifc_sdr.data, exp2_q.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Low byte goes out with the falling edge, high byte with the rising edge.
    task automatic send_word(input logic [15:0] w, input int half);
        @(negedge clk); lanes = w[7:0];  fclk = 1'b0; wait_cyc(half - 1);
        @(negedge clk); lanes = w[15:8]; fclk = 1'b1; wait_cyc(half - 1);
    endtask

    task automatic send_sdr(input logic [7:0] w, input int half);
        @(negedge clk); fclk2 = 1'b0; wait_cyc(half - 1);
        @(negedge clk); lanes2 = w; fclk2 = 1'b1; wait_cyc(half - 1);
    endtask

    initial begin
        rst_n = 1'b0; fclk = 1'b1; fclk2 = 1'b1; lanes = '0; lanes2 = '0;
        sdly = 4'd2; idle_cyc = '0; clr = 1'b0; rdy = 1'b1;
        #12;
        chk("rst_valid", ifc_ddr.valid, 1'b0);
        chk("rst_data", ifc_ddr.data, 16'h0);
        chk("rst_idle", idle_d1, 1'b1);
        chk("rst_edge_err", err_d1, 1'b0);
        chk("rst_overflow", ovf_d1, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        wait_cyc(3);

        // DDR basic at 8x oversampling
        exp_q.push_back(16'hA55A); exp_q.push_back(16'h1234);
        send_word(16'hA55A, 4);
        send_word(16'h1234, 4);
        wait_cyc(10); #2;
        chk("basic_edge_err", err_d1, 1'b0);
        chk("basic_idle", idle_d1, 1'b0);
        chk("basic_count", rx_log.size(), 2);
        chk("basic_first", rx_log[0], 16'hA55A);
        chk("basic_second", rx_log[1], 16'h1234);

        // Backpressure: only the first FifoDepth words survive
        @(negedge clk); rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) exp_q.push_back(16'h1001 + 16'(k));
            send_word(16'h1001 + 16'(k), 4);
        end
        wait_cyc(10); #2;
        chk("bp_overflow", ovf_d1, 1'b1);
        chk("bp_valid", ifc_ddr.valid, 1'b1);
        chk("bp_head", ifc_ddr.data, 16'h1001);
        @(negedge clk); rdy = 1'b1;
        wait_cyc(10); #2;
        chk("bp_drained", ifc_ddr.valid, 1'b0);
        chk("bp_all_popped", exp_q.size(), 0);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0; #2;
        chk("bp_overflow_cleared", ovf_d1, 1'b0);

        // Edge error: 4x ratio with a 7-cycle delay; no word can complete
        @(negedge clk); sdly = 4'd7;
        for (int k = 0; k < 3; k++) send_word(16'hFFFF, 2);
        wait_cyc(20); #2;
        chk("err_set", err_d1, 1'b1);

        // Recovery with a 1-cycle delay
        @(negedge clk); sdly = 4'd1; clr = 1'b1;
        @(negedge clk); clr = 1'b0; #2;
        chk("err_cleared", err_d1, 1'b0);
        exp_q.push_back(16'h0F0F); exp_q.push_back(16'hBEEF); exp_q.push_back(16'h7E81);
        send_word(16'h0F0F, 2);
        send_word(16'hBEEF, 2);
        send_word(16'h7E81, 2);
        wait_cyc(10); #2;
        chk("err_stays_clear", err_d1, 1'b0);
        chk("recovery_words", exp_q.size(), 0);

        // Idle: half word then a stopped clock; stale low byte must not merge
        @(negedge clk); sdly = 4'd2; idle_cyc = 8'd20;
        @(negedge clk); lanes = 8'hAB; fclk = 1'b0;
        wait_cyc(5); #2;
        chk("idle_active", idle_d1, 1'b0);
        wait_cyc(30); #2;
        chk("idle_set", idle_d1, 1'b1);
        @(negedge clk); lanes = 8'hCD; fclk = 1'b1;
        wait_cyc(4);
        exp_q.push_back(16'h00FF);
        send_word(16'h00FF, 4);
        wait_cyc(10); #2;
        chk("idle_resync_words", exp_q.size(), 0);
        chk("idle_resync_last", rx_log[rx_log.size()-1], 16'h00FF);
        chk("idle_cleared", idle_d1, 1'b0);
        @(negedge clk); idle_cyc = '0;

        // Async reset between fall and rise of a word
        @(negedge clk); rdy = 1'b0;
        send_word(16'h2468, 4);
        wait_cyc(6); #2;
        chk("rst_mid_prefill", ifc_ddr.valid, 1'b1);
        @(negedge clk); lanes = 8'h99; fclk = 1'b0;
        wait_cyc(2);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", ifc_ddr.valid, 1'b0);
        chk("rst_mid_idle", idle_d1, 1'b1);
        chk("rst_mid_data", ifc_ddr.data, 16'h0);
        fclk = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1; rdy = 1'b1;
        exp_q.push_back(16'h5AC3);
        send_word(16'h5AC3, 4);
        wait_cyc(10); #2;
        chk("rst_mid_words", exp_q.size(), 0);
        chk("rst_mid_last", rx_log[rx_log.size()-1], 16'h5AC3);

        // SDR instance: one word per rising edge
        exp2_q.push_back(8'h11); exp2_q.push_back(8'h22); exp2_q.push_back(8'h33);
        send_sdr(8'h11, 4);
        send_sdr(8'h22, 4);
        send_sdr(8'h33, 4);
        wait_cyc(10); #2;
        chk("sdr_pending", exp2_q.size(), 0);
        chk("sdr_count", rx2_log.size(), 3);
        chk("sdr_w0", rx2_log[0], 8'h11);
        chk("sdr_w1", rx2_log[1], 8'h22);
        chk("sdr_w2", rx2_log[2], 8'h33);
        chk("ddr_final_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
